// File: rtl/bcd_encoder.sv
// bcd_encoder: sequential packed-BCD to binary converter, one digit per clock
module bcd_encoder #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        number,
  output logic                    error
);
  localparam int AW = OUT_W + 4;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]              state_q, state_d;
  logic [4*NUM_DIGITS-1:0] sr_q, sr_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [OUT_W-1:0]        number_q, number_d;
  logic                    error_q, error_d;
  logic [3:0]              top;
  assign top    = sr_q[4*NUM_DIGITS-1 -: 4];
  assign busy   = busy_q;
  assign done   = done_q;
  assign number = number_q;
  assign error  = error_q;
  // next-state: latch on start, multiply-by-10-and-add per digit, publish result in DONE
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    number_d = number_q;
    error_d  = error_q;
    case (state_q)
      IDLE: if (start) begin
        sr_d    = digits;
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = CONV;
      end
      CONV: begin
        acc_d   = AW'(acc_q * AW'(10) + AW'(top));
        sr_d    = sr_q << 4;
        err_d   = err_q | (top > 4'd9);
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(NUM_DIGITS - 1)) ? DONE : CONV;
      end
      DONE: begin
        number_d = err_q ? '0 : acc_q[OUT_W-1:0];
        error_d  = err_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any conversion and clears the published result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      number_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      number_q <= number_d;
      error_q  <= error_d;
    end
  end
endmodule

// File: tb/tb_bcd_encoder.sv
// tb_bcd_encoder: randomized and directed checks of bcd_encoder against a decimal model
module tb_bcd_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic        busy, done, error;
  logic [13:0] number;
  int          checks = 0;
  int          errors = 0;

  bcd_encoder #(.NUM_DIGITS(4), .OUT_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digits(digits),
    .busy(busy), .done(done), .number(number), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [15:0] d);
    bit e = 0;
    for (int i = 0; i < 4; i++) if (int'(d[4*i +: 4]) > 9) e = 1;
    return e;
  endfunction

  function automatic int model_num(input logic [15:0] d);
    int n = 0;
    int p = 1;
    if (model_err(d)) return 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(d[4*i +: 4]) * p;
      p *= 10;
    end
    return n;
  endfunction

  task automatic run(input logic [15:0] d, input bit poke);
    @(negedge clk);
    digits = d;
    start  = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (poke && i == 1) begin start = 1'b1; digits = 16'h0007; end
      if (poke && i == 2) start = 1'b0;
      chk("busy", busy, i < 5);
      chk("done", done, i == 5);
      if (i >= 5) begin
        chk("number", number, model_num(d));
        chk("error", error, model_err(d));
      end
    end
  endtask

  initial begin
    logic [15:0] d;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_number", number, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
    run(16'h1234, 0);
    @(negedge clk);
    digits = 16'h9999;
    start  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) digits = 16'h0000;
      chk("held_done", done, i == 5 || i == 11);
      chk("held_busy", busy, !(i == 5 || i == 11));
      if (i == 5) chk("held_9999", number, 9999);
      if (i == 11) chk("held_0", number, 0);
    end
    start = 1'b0;
    run(16'h12A4, 0);
    run(16'h0042, 0);
    run(16'h1234, 1);
    repeat (3) begin
      @(negedge clk);
      chk("poke_no_done", done, 0);
    end
    @(negedge clk);
    digits = 16'h1234;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_number", number, 0);
    chk("abort_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run(16'h1234, 0);
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++)
        d[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      run(d, 0);
    end
    run(16'h9999, 0);
    run(16'h0000, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
